rotate_cordic: RTL

- Parametrised, sequential successor to the fixed-angle coordinate rotator.
- Rotates a signed (x, y) point by a run-time angle using an iterative CORDIC engine with a valid/ready handshake on both sides.
- Used by sprite/background transform logic that needs per-object rotation angles instead of one compile-time angle.
- Rotation sense matches the existing rotator: x_o = x·cosθ + y·sinθ, y_o = y·cosθ − x·sinθ (clockwise for positive θ).

---
 rtl/rotate_cordic.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/rotate_cordic.sv
// rotate_cordic -- iterative CORDIC rotator for signed (x, y) points.
//
// Rotates (x_i, y_i) clockwise by angle_i (units of 2^-AW turn):
//   x_o = x*cos(a) + y*sin(a),  y_o = y*cos(a) - x*sin(a)
// An input is accepted in IDLE on valid_i & ready_o. After the micro-rotations
// (and the optional gain-compensation step) the saturated result is held on
// x_o/y_o with valid_o high until ready_i.
//
// Build option:
//   GAIN_COMP_EN  defined   -> extra SCALE cycle multiplies by 1/K (unity gain)
//                 undefined -> outputs carry the CORDIC gain K ~= 1.6468
//
// Ports:
//   clk_i    system clock
//   rst_i    synchronous active-high reset
//   valid_i  input point/angle valid       ready_o  block can accept input
//   x_i/y_i  signed input point (W bits)   angle_i  rotation angle (AW bits)
//   valid_o  result valid                  ready_i  downstream accepts result
//   x_o/y_o  signed rotated point, saturated to W bits
module rotate_cordic #(
  parameter int W    = 10,
  parameter int AW   = 8,
  parameter int ITER = 12
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic signed [W-1:0] x_i,
  input  logic signed [W-1:0] y_i,
  input  logic [AW-1:0]       angle_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic signed [W-1:0] x_o,
  output logic signed [W-1:0] y_o
);

  localparam int XW = W + 3;
  localparam logic signed [31:0] SAT_MAX = (32'sd1 <<< (W - 1)) - 32'sd1;
  localparam logic signed [31:0] SAT_MIN = -(32'sd1 <<< (W - 1));

`ifdef GAIN_COMP_EN
  typedef enum logic [1:0] {S_IDLE, S_ROT, S_SCALE, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_ROT, S_DONE} state_t;
`endif

  state_t                state_q, state_d;
  logic [4:0]            cnt_q, cnt_d;
  logic signed [XW-1:0]  x_q, x_d, y_q, y_d;
  logic signed [15:0]    z_q, z_d;
  logic signed [W-1:0]   xo_q, xo_d, yo_q, yo_d;

  logic [15:0]           ang16;
  logic signed [XW-1:0]  xs, ys, xsh, ysh;

  // atan(2^-i) in units of 2^-16 turn
  function automatic logic signed [15:0] atan_tab(input logic [3:0] i);
    case (i)
      4'd0:    return 16'sd8192;
      4'd1:    return 16'sd4836;
      4'd2:    return 16'sd2555;
      4'd3:    return 16'sd1297;
      4'd4:    return 16'sd651;
      4'd5:    return 16'sd326;
      4'd6:    return 16'sd163;
      4'd7:    return 16'sd81;
      4'd8:    return 16'sd41;
      4'd9:    return 16'sd20;
      4'd10:   return 16'sd10;
      4'd11:   return 16'sd5;
      4'd12:   return 16'sd3;
      4'd13:   return 16'sd1;
      4'd14:   return 16'sd1;
      default: return 16'sd0;
    endcase
  endfunction

  // Arithmetic shift with round-to-nearest. Plain truncation pins small
  // negative terms at -1 and lets the late iterations walk x several LSB off.
  function automatic logic signed [XW-1:0] rshr(input logic signed [XW-1:0] v,
                                                input logic [4:0] sh);
    logic signed [31:0] t;
    t = 32'(v) + ((sh == 5'd0) ? 32'sd0 : (32'sd1 <<< (sh - 5'd1)));
    return XW'(t >>> sh);
  endfunction

  function automatic logic signed [W-1:0] sat_w(input logic signed [31:0] v);
    if (v > SAT_MAX) return W'(SAT_MAX);
    if (v < SAT_MIN) return W'(SAT_MIN);
    return W'(v);
  endfunction

`ifdef GAIN_COMP_EN
  // 622/1024 ~= 1/K, rounded
  function automatic logic signed [31:0] gain_fix(input logic signed [XW-1:0] v);
    logic signed [31:0] p;
    p = 32'(v) * 32'sd622 + 32'sd512;
    return p >>> 10;
  endfunction
`endif

  assign ang16   = 16'(angle_i) << (16 - AW);
  assign xs      = XW'(x_i);
  assign ys      = XW'(y_i);
  assign xsh     = rshr(x_q, cnt_q);
  assign ysh     = rshr(y_q, cnt_q);

  assign ready_o = (state_q == S_IDLE);
  assign valid_o = (state_q == S_DONE);
  assign x_o     = xo_q;
  assign y_o     = yo_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    unique case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          state_d = S_ROT;
          cnt_d   = '0;
          // Quadrant pre-rotation leaves a residual in [0, 90 deg)
          z_d     = {2'b00, ang16[13:0]};
          unique case (ang16[15:14])
            2'd0:    begin x_d = xs;  y_d = ys;  end
            2'd1:    begin x_d = ys;  y_d = -xs; end
            2'd2:    begin x_d = -xs; y_d = -ys; end
            default: begin x_d = -ys; y_d = xs;  end
          endcase
        end
      end
      S_ROT: begin
        if (cnt_q == 5'(ITER)) begin
`ifdef GAIN_COMP_EN
          state_d = S_SCALE;
`else
          state_d = S_DONE;
          xo_d    = sat_w(32'(x_q));
          yo_d    = sat_w(32'(y_q));
`endif
        end else begin
          cnt_d = cnt_q + 5'd1;
          if (!z_q[15]) begin
            x_d = x_q + ysh;
            y_d = y_q - xsh;
            z_d = z_q - atan_tab(cnt_q[3:0]);
          end else begin
            x_d = x_q - ysh;
            y_d = y_q + xsh;
            z_d = z_q + atan_tab(cnt_q[3:0]);
          end
        end
      end
`ifdef GAIN_COMP_EN
      S_SCALE: begin
        state_d = S_DONE;
        xo_d    = sat_w(gain_fix(x_q));
        yo_d    = sat_w(gain_fix(y_q));
      end
`endif
      S_DONE: begin
        if (ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
    end
  end

endmodule
